// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its synchroniser.
package reset_seq_pkg;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN, SWHOLD} rst_seq_state_e;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RELEASE_DLY = 16;
    localparam int DEF_HOLD_CYC    = 8;

    function automatic int cnt_width(input int release_dly, input int hold_cyc);
        int m;
        m = (release_dly > hold_cyc) ? release_dly : hold_cyc;
        return $clog2(m + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_RELEASE_DLY, DEF_HOLD_CYC);

endpackage

// File: rtl/reset_sync.sv
// Pad reset synchroniser: asserts immediately with rst_async, releases after
// SYNC_STAGES rising edges of clk.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_async,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS active-low domain resets one by one, RELEASE_DLY cycles
// apart, after the pad reset is synchronised; a software request re-runs it.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RELEASE_DLY = DEF_RELEASE_DLY,
    parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   busy,
    output logic                   all_released
);

    localparam int CNT_W      = cnt_width(RELEASE_DLY, HOLD_CYC);
    localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int REL_LAST_I = (RELEASE_DLY > 1) ? RELEASE_DLY - 2 : 0;
    localparam bit SINGLE_STEP = (RELEASE_DLY == 1);

    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_LAST_I);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    logic                   rst_sync_n;
    rst_seq_state_e         state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] rst_n_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   all_rel_q;
    logic                   release_now;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_sync_n(rst_sync_n)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // HOLD stops one cycle short so the RELEASE cycle completes the RELEASE_DLY gap.
    assign release_now = (state_q == RELEASE) || (SINGLE_STEP && (state_q == HOLD));

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_n_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b1;
            all_rel_q <= 1'b0;
        end else if (rst_sync_n) begin
            ack_q <= 1'b0;
            if (sw_rst_req && (state_q != SWHOLD)) begin
                rst_n_q   <= '0;
                ack_q     <= 1'b1;
                busy_q    <= 1'b1;
                all_rel_q <= 1'b0;
                state_q   <= SWHOLD;
                cnt_q     <= '0;
                idx_q     <= '0;
            end else if (release_now) begin
                rst_n_q[idx_q] <= 1'b1;
                cnt_q          <= '0;
                if (idx_q == IDX_LAST) begin
                    state_q   <= RUN;
                    busy_q    <= 1'b0;
                    all_rel_q <= 1'b1;
                end else begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= SINGLE_STEP ? RELEASE : HOLD;
                end
            end else begin
                case (state_q)
                    HOLD: begin
                        if (cnt_q == REL_LAST) begin
                            cnt_q   <= '0;
                            state_q <= RELEASE;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    SWHOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            cnt_q <= '0;
                            if (!sw_rst_req) begin
                                state_q <= HOLD;
                                idx_q   <= '0;
                            end
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    default: begin
                        cnt_q <= cnt_q;
                    end
                endcase
            end
        end
    end

    assign sw_rst_ack   = ack_q;
    assign rst_n_o      = rst_n_q;
    assign busy         = busy_q;
    assign all_released = all_rel_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: release-timing table applied after each
// reset source, scoreboard of per-cycle expectations, plus running invariants.
module tb_reset_sequencer;

    typedef struct {
        int         offset;
        logic [3:0] rstN;
        logic       busy;
        logic       allRel;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] rstN;
        logic       ack;
        logic       busy;
        logic       allRel;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_async = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       sw_rst_ack;
    logic [3:0] rst_n_o;
    logic       busy;
    logic       all_released;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ackCount = 0;
    logic prevAck = 1'b0;
    exp_t expQ[$];
    vec_t relTable[11];

    reset_sequencer #(
        .NUM_DOMAINS(4),
        .SYNC_STAGES(2),
        .RELEASE_DLY(16),
        .HOLD_CYC   (8)
    ) dut (
        .clk         (clk),
        .rst_async   (rst_async),
        .sw_rst_req  (sw_rst_req),
        .sw_rst_ack  (sw_rst_ack),
        .rst_n_o     (rst_n_o),
        .busy        (busy),
        .all_released(all_released)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int c, input logic [3:0] r, input logic a, input logic b,
                           input logic ar, input string name);
        exp_t e;
        e.cyc = c; e.rstN = r; e.ack = a; e.busy = b; e.allRel = ar; e.name = name;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int base, input int maxOff);
        for (int i = 0; i < 11; i++) begin
            if (relTable[i].offset <= maxOff) begin
                pushExp(base + relTable[i].offset, relTable[i].rstN, 1'b0, relTable[i].busy,
                        relTable[i].allRel, $sformatf("rel+%0d", relTable[i].offset));
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) waitCycles(1);
    endtask

    task automatic pulseReq(output int accCyc);
        sw_rst_req = 1'b1;
        accCyc = cyc + 1;
        pushExp(accCyc, 4'b0000, 1'b1, 1'b1, 1'b0, "ackEdge");
        pushExp(accCyc + 1, 4'b0000, 1'b0, 1'b1, 1'b0, "ackDrop");
        waitCycles(1);
        sw_rst_req = 1'b0;
    endtask

    // Scoreboard drain plus invariants, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic ordered;
        logic notAll;
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            if (e.cyc < cyc) begin
                checkOutput({e.name, " late"}, cyc, e.cyc);
            end else begin
                checkOutput({e.name, " rst_n_o"}, rst_n_o, e.rstN);
                checkOutput({e.name, " ack"}, sw_rst_ack, e.ack);
                checkOutput({e.name, " busy"}, busy, e.busy);
                checkOutput({e.name, " all_released"}, all_released, e.allRel);
            end
        end
        ordered = 1'b1;
        for (int k = 1; k < 4; k++) begin
            if (rst_n_o[k] && !rst_n_o[k-1]) ordered = 1'b0;
        end
        checkOutput("order", ordered, 1'b1);
        notAll = ~all_released;
        checkOutput("busyVsAllRel", busy, notAll);
        if (sw_rst_ack) begin
            ackCount++;
            checkOutput("ackPulseWidth", prevAck, 1'b0);
        end
        prevAck = sw_rst_ack;
    end

    initial begin : stim
        int s;
        int a;
        int b;
        int acks0;
        int guard;

        relTable[0]  = '{-1, 4'b0000, 1'b1, 1'b0};
        relTable[1]  = '{ 0, 4'b0000, 1'b1, 1'b0};
        relTable[2]  = '{15, 4'b0000, 1'b1, 1'b0};
        relTable[3]  = '{16, 4'b0001, 1'b1, 1'b0};
        relTable[4]  = '{31, 4'b0001, 1'b1, 1'b0};
        relTable[5]  = '{32, 4'b0011, 1'b1, 1'b0};
        relTable[6]  = '{47, 4'b0011, 1'b1, 1'b0};
        relTable[7]  = '{48, 4'b0111, 1'b1, 1'b0};
        relTable[8]  = '{63, 4'b0111, 1'b1, 1'b0};
        relTable[9]  = '{64, 4'b1111, 1'b0, 1'b1};
        relTable[10] = '{70, 4'b1111, 1'b0, 1'b1};

        // Power-up: reset values appear with no clock edge.
        #1 rst_async = 1'b0;
        #1;
        checkOutput("reset rst_n_o", rst_n_o, 4'b0000);
        checkOutput("reset busy", busy, 1'b1);
        checkOutput("reset all_released", all_released, 1'b0);
        checkOutput("reset ack", sw_rst_ack, 1'b0);
        waitCycles(5);
        rst_async = 1'b1;
        s = cyc + 2;
        $display("[TB] power-up release, sync edge %0d", s);
        applyStimulus(s, 100);
        waitUntil(s + 71);

        // Software request in RUN.
        acks0 = ackCount;
        pulseReq(a);
        applyStimulus(a + 8, 100);
        waitUntil(a + 8 + 71);
        checkOutput("ackCount run", ackCount - acks0, 1);

        // Request mid-sequence while rst_n_o == 0011.
        acks0 = ackCount;
        pulseReq(a);
        applyStimulus(a + 8, 32);
        waitUntil(a + 8 + 36);
        pushExp(cyc, 4'b0011, 1'b0, 1'b1, 1'b0, "midSeq");
        pulseReq(b);
        applyStimulus(b + 8, 100);
        waitUntil(b + 8 + 71);
        checkOutput("ackCount mid", ackCount - acks0, 2);

        // Request held for 30 cycles: SWHOLD restarts until it drops.
        acks0 = ackCount;
        sw_rst_req = 1'b1;
        a = cyc + 1;
        pushExp(a, 4'b0000, 1'b1, 1'b1, 1'b0, "heldAck");
        for (int i = 1; i <= 30; i++) pushExp(a + i, 4'b0000, 1'b0, 1'b1, 1'b0, "heldSwHold");
        waitCycles(30);
        sw_rst_req = 1'b0;
        applyStimulus(a + 32, 100);
        waitUntil(a + 32 + 71);
        checkOutput("ackCount held", ackCount - acks0, 1);

        // Asynchronous pad reset between edges while in RUN.
        checkOutput("preAsync all_released", all_released, 1'b1);
        @(posedge clk);
        #2 rst_async = 1'b0;
        #1;
        checkOutput("async rst_n_o", rst_n_o, 4'b0000);
        checkOutput("async busy", busy, 1'b1);
        checkOutput("async all_released", all_released, 1'b0);
        checkOutput("async ack", sw_rst_ack, 1'b0);
        waitCycles(3);
        rst_async = 1'b1;
        s = cyc + 2;
        applyStimulus(s, 16);
        waitUntil(s + 17);

        guard = 0;
        while (expQ.size() > 0 && guard < 50) begin
            waitCycles(1);
            guard++;
        end
        if (expQ.size() > 0) checkOutput("drain", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
